// File: rtl/fpu_instr_enc_pkg.sv
// Shared constants and types for the RV64D OP-FP instruction encoder.
// Op codes, funct5 values and the fixed opcode/format fields live here.
package fpu_instr_enc_pkg;

   localparam logic [4:0] OP_FADD   = 5'b00000;
   localparam logic [4:0] OP_FSUB   = 5'b00001;
   localparam logic [4:0] OP_FMUL   = 5'b00010;
   localparam logic [4:0] OP_FDIV   = 5'b00011;
   localparam logic [4:0] OP_FSQRT  = 5'b00100;
   localparam logic [4:0] OP_FCVTLD = 5'b00101;
   localparam logic [4:0] OP_FCVTDL = 5'b00110;
   localparam logic [4:0] OP_FMVXD  = 5'b00111;
   localparam logic [4:0] OP_FMVDX  = 5'b01000;

   localparam logic [4:0] F5_ADD    = 5'b00000;
   localparam logic [4:0] F5_SUB    = 5'b00001;
   localparam logic [4:0] F5_MUL    = 5'b00010;
   localparam logic [4:0] F5_DIV    = 5'b00011;
   localparam logic [4:0] F5_SQRT   = 5'b01011;
   localparam logic [4:0] F5_FCVTLD = 5'b11000;
   localparam logic [4:0] F5_FCVTDL = 5'b11010;
   localparam logic [4:0] F5_FMVXD  = 5'b11100;
   localparam logic [4:0] F5_FMVDX  = 5'b11110;

   localparam logic [6:0] OPCODE_OP_FP = 7'b1010011;
   localparam logic [1:0] FMT_D        = 2'b01;

   // rs2 field selects the integer width for fcvt between L and D
   localparam logic [4:0] RS2F_CVT_L = 5'b00010;

   typedef struct packed {
      logic [4:0] funct5;
      logic [1:0] fmt;
      logic [4:0] rs2;
      logic [4:0] rs1;
      logic [2:0] rm;
      logic [4:0] rd;
      logic [6:0] opcode;
   } fp_instr_t;

   function automatic fp_instr_t mk_instr(
      input logic [4:0] f5,
      input logic [4:0] rs2f,
      input logic [4:0] rs1,
      input logic [2:0] rmf,
      input logic [4:0] rd
   );
      fp_instr_t w;
      w.funct5 = f5;
      w.fmt    = FMT_D;
      w.rs2    = rs2f;
      w.rs1    = rs1;
      w.rm     = rmf;
      w.rd     = rd;
      w.opcode = OPCODE_OP_FP;
      return w;
   endfunction

endpackage

// File: rtl/fpu_instr_enc_pack.sv
// Combinational op-to-word encoder for double-precision OP-FP instructions.
// Unknown op codes produce an all-zero word and deassert legal_o.
module fpu_instr_pack
   import fpu_instr_enc_pkg::*;
(
   input  logic [4:0]  op_i,
   input  logic [4:0]  rd_i,
   input  logic [4:0]  rs1_i,
   input  logic [4:0]  rs2_i,
   input  logic [2:0]  rm_i,
   output logic [31:0] word_o,
   output logic        legal_o
);

   fp_instr_t w;

   always_comb begin
      w       = '0;
      legal_o = 1'b1;
      unique case (op_i)
         OP_FADD:   w = mk_instr(F5_ADD, rs2_i, rs1_i, rm_i, rd_i);
         OP_FSUB:   w = mk_instr(F5_SUB, rs2_i, rs1_i, rm_i, rd_i);
         OP_FMUL:   w = mk_instr(F5_MUL, rs2_i, rs1_i, rm_i, rd_i);
         OP_FDIV:   w = mk_instr(F5_DIV, rs2_i, rs1_i, rm_i, rd_i);
         OP_FSQRT:  w = mk_instr(F5_SQRT, 5'd0, rs1_i, rm_i, rd_i);
         OP_FCVTLD: w = mk_instr(F5_FCVTLD, RS2F_CVT_L,
                                 rs1_i, rm_i, rd_i);
         OP_FCVTDL: w = mk_instr(F5_FCVTDL, RS2F_CVT_L,
                                 rs1_i, rm_i, rd_i);
         // moves are bit-exact, so the rm field is fixed to zero
         OP_FMVXD:  w = mk_instr(F5_FMVXD, 5'd0, rs1_i, 3'd0, rd_i);
         OP_FMVDX:  w = mk_instr(F5_FMVDX, 5'd0, rs1_i, 3'd0, rd_i);
         default: begin
            w       = '0;
            legal_o = 1'b0;
         end
      endcase
   end

   assign word_o = w;

endmodule

// File: rtl/fpu_instr_enc.sv
// OP-FP encoder with a DEPTH-entry output FIFO of encoded words.
// Define FPU_ENC_ILLEGAL_CHK_EN to drop illegal ops and flag them.
module fpu_instr_enc
   import fpu_instr_enc_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [4:0]               fpu_op,
   input  logic [4:0]               rd,
   input  logic [4:0]               rs1,
   input  logic [4:0]               rs2,
   input  logic [2:0]               rm,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [31:0]              instr,
   output logic [$clog2(DEPTH):0]   count
`ifdef FPU_ENC_ILLEGAL_CHK_EN
   ,output logic                    illegal
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [31:0]   word;
   logic [31:0]   wdata;
   logic          legal;
   logic          push;
   logic          pop;
   logic          enq;
   logic          full;
   logic          empty;

   logic [AW-1:0] wr_q, wr_d;
   logic [AW-1:0] rd_q, rd_d;
   logic [AW:0]   cnt_q, cnt_d;
   logic [31:0]   mem_q [DEPTH];

   fpu_instr_pack u_pack (
      .op_i    (fpu_op),
      .rd_i    (rd),
      .rs1_i   (rs1),
      .rs2_i   (rs2),
      .rm_i    (rm),
      .word_o  (word),
      .legal_o (legal)
   );

   assign wdata = legal ? word : 32'd0;

   assign full  = (cnt_q == FULL_CNT);
   assign empty = (cnt_q == '0);

   // in_ready depends only on stored state; a pop never frees a slot early
   assign in_ready  = !full;
   assign out_valid = !empty;
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

`ifdef FPU_ENC_ILLEGAL_CHK_EN
   logic illegal_q;

   assign enq     = push && legal;
   assign illegal = illegal_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         illegal_q <= 1'b0;
      end else begin
         illegal_q <= push && !legal;
      end
   end
`else
   assign enq = push;
`endif

   always_comb begin
      wr_d  = wr_q;
      rd_d  = rd_q;
      cnt_d = cnt_q;
      if (enq) begin
         wr_d = wr_q + 1'b1;
      end
      if (pop) begin
         rd_d = rd_q + 1'b1;
      end
      unique case ({enq, pop})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

   // storage needs no reset: entries are only visible while counted
   always_ff @(posedge clk) begin
      if (enq) begin
         mem_q[wr_q] <= wdata;
      end
   end

   assign instr = empty ? 32'd0 : mem_q[rd_q];
   assign count = cnt_q;

endmodule

// File: tb/tb_fpu_instr_enc.sv
// Directed self-checking bench for fpu_instr_enc (DEPTH = 4).
// Build with FPU_ENC_ILLEGAL_CHK_EN to exercise the illegal-op flag.
module tb_fpu_instr_enc;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [4:0]  fpu_op;
   logic [4:0]  rd;
   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic [2:0]  rm;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] instr;
   logic [2:0]  count;
`ifdef FPU_ENC_ILLEGAL_CHK_EN
   logic        illegal;
`endif

   int tests = 0;
   int fails = 0;
   logic [31:0] exp_q [$];

   fpu_instr_enc #(.DEPTH(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .fpu_op    (fpu_op),
      .rd        (rd),
      .rs1       (rs1),
      .rs2       (rs2),
      .rm        (rm),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .instr     (instr),
      .count     (count)
`ifdef FPU_ENC_ILLEGAL_CHK_EN
      ,.illegal  (illegal)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] want);
      tests++;
      assert (got === want) else begin
         fails++;
         $error("FAIL %s: got %h want %h", tag, got, want);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic req(input logic [4:0] op, input logic [4:0] d,
                      input logic [4:0] s1, input logic [4:0] s2,
                      input logic [2:0] r);
      in_valid = 1'b1;
      fpu_op   = op;
      rd       = d;
      rs1      = s1;
      rs2      = s2;
      rm       = r;
   endtask

   function automatic logic [31:0] fadd_rd(input int k);
      logic [31:0] w;
      w = 32'h0200_0053;
      w[11:7] = k[4:0];
      return w;
   endfunction

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      fpu_op = '0; rd = '0; rs1 = '0; rs2 = '0; rm = '0;
      #2;
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_oval", 32'(out_valid), 32'd0);
      chk("rst_irdy", 32'(in_ready), 32'd1);
      chk("rst_instr", instr, 32'd0);
      step(); step();
      rst = 1'b0;
      step();

      // single fadd.d, then fmul.d pushed while popping it
      req(5'b00000, 5'd1, 5'd2, 5'd3, 3'b000);
      step();
      chk("fadd_oval", 32'(out_valid), 32'd1);
      chk("fadd_instr", instr, 32'h0231_00D3);
      chk("fadd_count", 32'(count), 32'd1);
      req(5'b00010, 5'd7, 5'd7, 5'd7, 3'b111);
      out_ready = 1'b1;
      step();
      chk("fmul_count", 32'(count), 32'd1);
      chk("fmul_instr", instr, 32'h1273_F3D3);
      in_valid = 1'b0;
      step();
      chk("empty_count", 32'(count), 32'd0);
      chk("empty_instr", instr, 32'd0);
      step();
      chk("pop_empty_cnt", 32'(count), 32'd0);

      // fsqrt.d drops rs2, fmv.x.d drops rm
      out_ready = 1'b0;
      req(5'b00100, 5'd4, 5'd5, 5'd7, 3'b001);
      step();
      req(5'b00111, 5'd6, 5'd8, 5'd9, 3'b111);
      step();
      in_valid = 1'b0;
      chk("sqrt_instr", instr, 32'h5A02_9253);
      chk("two_count", 32'(count), 32'd2);
      out_ready = 1'b1;
      step();
      chk("fmvxd_instr", instr, 32'hE204_0353);
      step();
      chk("drain_count", 32'(count), 32'd0);

      // fill to full, hold off the fifth request
      out_ready = 1'b0;
      req(5'b00101, 5'd10, 5'd11, 5'd31, 3'b010);
      step();
      req(5'b00110, 5'd1, 5'd1, 5'd0, 3'b100);
      step();
      req(5'b01000, 5'd31, 5'd31, 5'd31, 3'b111);
      step();
      req(5'b00001, 5'd3, 5'd4, 5'd5, 3'b011);
      step();
      chk("full_count", 32'(count), 32'd4);
      chk("full_irdy", 32'(in_ready), 32'd0);
      req(5'b00011, 5'd2, 5'd3, 5'd4, 3'b000);
      step();
      chk("held_count", 32'(count), 32'd4);
      chk("held_head", instr, 32'hC225_A553);
      out_ready = 1'b1;
      step();
      chk("nobypass_cnt", 32'(count), 32'd3);
      chk("reopen_irdy", 32'(in_ready), 32'd1);
      out_ready = 1'b0;
      step();
      in_valid = 1'b0;
      chk("refill_count", 32'(count), 32'd4);
      out_ready = 1'b1;
      chk("ord_fcvtdl", instr, 32'hD220_C0D3);
      step();
      chk("ord_fmvdx", instr, 32'hF20F_8FD3);
      step();
      chk("ord_fsub", instr, 32'h0A52_31D3);
      step();
      chk("ord_fdiv", instr, 32'h1A41_8153);
      step();
      chk("ord_empty", 32'(out_valid), 32'd0);

      // steady push+pop at count 2 across pointer wrap
      out_ready = 1'b0;
      exp_q.delete();
      for (int k = 0; k < 2; k++) begin
         req(5'b00000, 5'(k), 5'd0, 5'd0, 3'b000);
         exp_q.push_back(fadd_rd(k));
         step();
      end
      out_ready = 1'b1;
      for (int k = 2; k < 12; k++) begin
         req(5'b00000, 5'(k), 5'd0, 5'd0, 3'b000);
         chk($sformatf("wrap_head%0d", k), instr, exp_q[0]);
         step();
         void'(exp_q.pop_front());
         exp_q.push_back(fadd_rd(k));
         chk($sformatf("wrap_cnt%0d", k), 32'(count), 32'd2);
      end
      in_valid = 1'b0;
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("wrap_tail%0d", k), instr, exp_q[0]);
         void'(exp_q.pop_front());
         step();
      end
      chk("wrap_empty", 32'(count), 32'd0);

      // illegal op code
      out_ready = 1'b0;
      req(5'b11111, 5'd1, 5'd2, 5'd3, 3'b000);
      chk("ill_irdy", 32'(in_ready), 32'd1);
      step();
      in_valid = 1'b0;
`ifdef FPU_ENC_ILLEGAL_CHK_EN
      chk("ill_pulse", 32'(illegal), 32'd1);
      chk("ill_count", 32'(count), 32'd0);
      step();
      chk("ill_low", 32'(illegal), 32'd0);
`else
      chk("ill_count", 32'(count), 32'd1);
      chk("ill_oval", 32'(out_valid), 32'd1);
      chk("ill_instr", instr, 32'd0);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("ill_drain", 32'(count), 32'd0);
`endif

      // asynchronous reset with three queued entries
      for (int k = 0; k < 3; k++) begin
         req(5'b00000, 5'(k + 20), 5'd0, 5'd0, 3'b000);
         step();
      end
      chk("pre_rst_cnt", 32'(count), 32'd3);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_count", 32'(count), 32'd0);
      chk("arst_oval", 32'(out_valid), 32'd0);
      chk("arst_instr", instr, 32'd0);
      chk("arst_irdy", 32'(in_ready), 32'd1);
      step();
      chk("rst_noacc", 32'(count), 32'd0);
      #2;
      in_valid = 1'b0;
      rst = 1'b0;
      step();
      chk("post_rst_cnt", 32'(count), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/fpu_instr_enc.md
FPU_INSTR_ENC -- requirements
Module: fpu_instr_enc

Interface
REQ-001 SHALL have parameter DEPTH, default 4; FIFO entries, power of two, 2..16.
REQ-002 SHALL have port clk input 1; the single clock, all state on rising edge.
REQ-003 SHALL have port rst input 1; asynchronous, active-high reset.
REQ-004 SHALL have port in_valid input 1; an encode request is present.
REQ-005 SHALL have port in_ready output 1; the block accepts the request this cycle.
REQ-006 SHALL have port fpu_op input 5; op code: 00000 fadd.d, 00001 fsub.d, 00010 fmul.d, 00011 fdiv.d, 00100 fsqrt.d, 00101 fcvt.l.d, 00110 fcvt.d.l, 00111 fmv.x.d, 01000 fmv.d.x.
REQ-007 SHALL have ports rd, rs1 and rs2, each input 5; register indices.
REQ-008 SHALL have port rm input 3; rounding mode.
REQ-009 SHALL have port out_valid output 1; the head instruction is valid.
REQ-010 SHALL have port out_ready input 1; the consumer takes the head.
REQ-011 SHALL have port instr output 32; the encoded instruction at the FIFO head.
REQ-012 SHALL have port count output log2(DEPTH)+1; occupancy.

Function
REQ-013 Push SHALL occur on in_valid&&in_ready; pop SHALL occur on out_valid&&out_ready.
REQ-014 in_ready SHALL be !full, registered-state only; there is no same-cycle bypass when full, even if popping.
REQ-015 out_valid SHALL be count!=0; instr SHALL equal the head entry; instr SHALL be 0 when empty.
REQ-016 Latency: a request pushed at edge N SHALL be visible on instr/out_valid after edge N when the FIFO was empty.
REQ-017 Encoding SHALL be instr = {funct5, 2'b01, rs2f, rs1, rmf, rd, 7'b1010011}.
REQ-018 funct5 SHALL be: add 00000, sub 00001, mul 00010, div 00011, sqrt 01011, fcvt.l.d 11000, fcvt.d.l 11010, fmv.x.d 11100, fmv.d.x 11110.
REQ-019 rs2f SHALL be rs2 for add/sub/mul/div; 00000 for sqrt/fmv.*; 00010 for fcvt.l.d/fcvt.d.l.
REQ-020 rmf SHALL be rm, except 000 for fmv.x.d/fmv.d.x.
REQ-021 Encoding SHALL occur at push, with the FIFO storing 32-bit words.
REQ-022 Simultaneous push and pop SHALL leave count unchanged, with both pointers advancing.
REQ-023 Pointers SHALL wrap modulo DEPTH, and FIFO order SHALL be preserved across wrap.
REQ-024 Pop on empty and push on full SHALL be impossible by handshake, and state SHALL be unchanged.

Reset
REQ-025 On rst, pointers and count SHALL be 0, out_valid 0, in_ready 1 and instr 0, immediately (asynchronous).
REQ-026 Reset mid-operation SHALL discard all queued entries; a request presented during reset SHALL not be accepted.

Configuration
REQ-027 With FPU_ENC_ILLEGAL_CHK_EN defined, fpu_op > 01000 SHALL be accepted (in_ready honoured) but not enqueued, and output illegal (1 bit) SHALL pulse high for one cycle after the accepting edge (reset 0).
REQ-028 Without FPU_ENC_ILLEGAL_CHK_EN, the illegal port SHALL be absent and an illegal fpu_op SHALL enqueue 32'h00000000.

Structure
REQ-029 A shared package SHALL hold the fpu_op code constants, funct5 constants, OPCODE_OP_FP = 7'b1010011 and FMT_D = 2'b01.
REQ-030 Sub-module fpu_instr_pack SHALL perform the combinational op-to-word encoding; the parent SHALL hold the FIFO and handshake logic.

Verification
REQ-031 fadd.d: push fadd.d, rd=1, rs1=2, rs2=3, rm=000 into an empty FIFO -> next cycle out_valid=1, instr=32'h023100D3.
REQ-032 Special fields: push fsqrt.d rs2=7, then fmv.x.d rm=111 -> rs2 field 0 for fsqrt.d; rm field 000 for fmv.x.d.
REQ-033 Full FIFO: with out_ready=0, push 4 requests -> count=4, in_ready=0; 5th request held off; then one pop -> in_ready=1 the next cycle.
REQ-034 Wrap: simultaneous push and pop for 10 cycles at count=2 -> count stays 2; output order matches input order across wrap.
REQ-035 Mid-stream reset: assert rst with 3 entries queued -> count=0, out_valid=0 asynchronously.
REQ-036 Illegal op: push fpu_op=11111 -> with FPU_ENC_ILLEGAL_CHK_EN, illegal pulses and count is unchanged; without it, instr=0 is enqueued.
